echo_detector: RTL
==================

Name: echo_detector

Overview:
Consumes the receive-beamformer's aggregated waveform samples (16-bit, qualified by the ADC data-valid strobe) together with the free-running time-since-emission counter. Replaces the single-compare echo flag with a qualified detector that does three things:
- blanks the transmit burst and ring-down period;
- requires a run of consecutive above-threshold samples;
- tracks the echo peak with hysteresis.

Reports the echo's arrival time and peak to the time-of-flight and display stages. Also reports an explicit no-echo timeout, once per ping.

Parameters:
DATA_WIDTH, 16, width of aggregated waveform sample
TIME_WIDTH, 24, width of time-since-emission count
THRESHOLD, 200, detection level; a sample qualifies when strictly greater
HYSTERESIS, 50, echo ends when sample < THRESHOLD-HYSTERESIS (must be <= THRESHOLD)
CONFIRM_COUNT, 4, consecutive qualifying valid samples needed to declare an echo (>=1)
BLANK_CYCLES, 600000, time_since_emission value below which samples are ignored
WINDOW_CYCLES, 16000000, time_since_emission value at/after which the listen window closes (> BLANK_CYCLES)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  asynchronous, active-low reset
burst_start_in  input  1  one-cycle pulse at start of each ping; synchronous restart
data_valid_in  input  1  sample strobe (one cycle per ADC conversion)
sample_in  input  DATA_WIDTH  unsigned aggregated waveform
time_in  input  TIME_WIDTH  cycles since emission
echo_detected_out  output  1  level; high from confirmation until next burst_start_in
echo_valid_out  output  1  one-cycle pulse when echo ends; time/peak outputs valid
no_echo_out  output  1  one-cycle pulse when window closes with no confirmed echo
echo_time_out  output  TIME_WIDTH  time_in of first sample of the confirmed run
peak_out  output  DATA_WIDTH  maximum sample seen from run start to echo end
busy_out  output  1  high in BLANK, ARMED, CONFIRM, TRACK

Behaviour:
- Reset (rst_n_in low, async): state=IDLE; all outputs 0; run counter, captured time and peak registers 0.
- States: IDLE, BLANK, ARMED, CONFIRM, TRACK, DONE. All transitions are registered.
- burst_start_in has highest priority in every state, including mid-TRACK:
  - next state BLANK;
  - clears echo_detected_out, echo_time_out, peak_out and the run counter;
  - any sample presented in the same cycle is ignored.
- Samples are evaluated only in cycles with data_valid_in=1. time_in is captured in the same cycle as the sample.
- IDLE: waits for burst_start_in.
- BLANK: moves to ARMED on the first cycle with time_in >= BLANK_CYCLES. A valid sample in that same cycle is evaluated as ARMED.
- ARMED: on a valid sample > THRESHOLD:
  - capture time_in as the candidate time and the sample as the candidate peak;
  - run=1;
  - if CONFIRM_COUNT==1, go to TRACK, otherwise go to CONFIRM.
- CONFIRM:
  - valid sample > THRESHOLD: run+1 and peak=max(peak, sample). When run reaches CONFIRM_COUNT, go to TRACK.
  - valid sample <= THRESHOLD: run=0, go to ARMED, discard the candidate.
- Entering TRACK:
  - echo_detected_out rises the cycle after the confirming sample;
  - echo_time_out is driven from the candidate time at the same moment.
- TRACK:
  - each valid sample updates peak=max(peak, sample);
  - a valid sample < THRESHOLD-HYSTERESIS ends the echo: go to DONE, echo_valid_out=1 for one cycle, peak_out holds the final peak;
  - samples between the two levels keep TRACK.
- Window close: time_in >= WINDOW_CYCLES is checked every cycle.
  - In ARMED or CONFIRM: go to DONE with a no_echo_out pulse. echo_time_out and peak_out stay 0.
  - In TRACK: go to DONE with an echo_valid_out pulse (echo truncated).
  - If a sample ends the echo in the same cycle as the window closes: exactly one echo_valid_out pulse.
- DONE: holds all outputs (echo_detected_out stays high if an echo was found) until burst_start_in.
- At most one of echo_valid_out / no_echo_out per ping. Never both; never repeated.
- Arithmetic:
  - comparisons are unsigned;
  - THRESHOLD-HYSTERESIS is a constant, computed at elaboration;
  - the run counter is clog2(CONFIRM_COUNT+1) bits and saturates.
- data_valid_in outside BLANK..TRACK is ignored.

Optional Feature:
ECHO_DET_MOVING_AVG_EN
- Defined: compares use a 4-tap moving average of valid samples. The sum is DATA_WIDTH+2 bits, shifted right by 2; peak_out records averaged values.
  - The average is registered, adding 1 cycle of latency to every decision. The captured time is the time_in of the newest sample in the window.
  - The tap history is cleared by burst_start_in and by reset.
  - Averages are not evaluated until 4 valid samples have arrived since burst_start_in.
- Undefined: raw samples are compared directly, with no extra latency.

Test Plan:
Bench params for all scenarios: BLANK_CYCLES=100, WINDOW_CYCLES=2000, CONFIRM_COUNT=3, THRESHOLD=200, HYSTERESIS=50.
- Burst at t=0; sample 1000 at time 50; then samples 0 until time 2000. Expected: blanked sample ignored; no_echo_out pulses once when time_in hits 2000; echo_time_out=0.
- Valid samples 210,220,190 at times 300/400/500, then 250,300,260 at 600/700/800, then 100 at 900. Expected:
  - 190 breaks the first run;
  - echo_detected_out rises one cycle after the 800 sample; echo_time_out=600;
  - echo_valid_out pulses after the 900 sample with peak_out=300.
- Confirmed echo, then samples 160 (hold) and 149 (end). Expected: 160 keeps TRACK; 149 gives echo_valid_out.
- Echo confirmed, then samples stay 400 until time 2000. Expected: exactly one echo_valid_out; no no_echo_out; peak_out=400.
- burst_start_in asserted mid-TRACK, concurrent with data_valid_in. Expected: state BLANK; echo_detected_out=0; no pulse; the concurrent sample is ignored.
- rst_n_in asserted asynchronously mid-CONFIRM. Expected: all outputs 0 immediately; IDLE until the next burst_start_in.

Source files
------------

// File: rtl/echo_detector.sv
// Qualified echo detector: blanking, confirmation run, hysteresis peak tracking and
// a once-per-ping no-echo timeout. Define ECHO_DET_MOVING_AVG_EN to compare 4-tap averages.
module echo_detector #(
    parameter int DATA_WIDTH    = 16,
    parameter int TIME_WIDTH    = 24,
    parameter int THRESHOLD     = 200,
    parameter int HYSTERESIS    = 50,
    parameter int CONFIRM_COUNT = 4,
    parameter int BLANK_CYCLES  = 600000,
    parameter int WINDOW_CYCLES = 16000000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  burst_start_in,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic [TIME_WIDTH-1:0] time_in,
    output logic                  echo_detected_out,
    output logic                  echo_valid_out,
    output logic                  no_echo_out,
    output logic [TIME_WIDTH-1:0] echo_time_out,
    output logic [DATA_WIDTH-1:0] peak_out,
    output logic                  busy_out
);
    typedef enum logic [2:0] {IDLE, BLANK, ARMED, CONFIRM, TRACK, DONE} state_t;

    localparam int RW = $clog2(CONFIRM_COUNT + 1);
    localparam logic [DATA_WIDTH-1:0] TH        = DATA_WIDTH'(THRESHOLD);
    localparam logic [DATA_WIDTH-1:0] LOW       = DATA_WIDTH'(THRESHOLD - HYSTERESIS);
    localparam logic [TIME_WIDTH-1:0] BLANK_T   = TIME_WIDTH'(BLANK_CYCLES);
    localparam logic [TIME_WIDTH-1:0] WIN_T     = TIME_WIDTH'(WINDOW_CYCLES);
    localparam logic [RW-1:0]         CONF_LAST = RW'(CONFIRM_COUNT - 1);
    localparam logic [RW-1:0]         CONF_MAX  = RW'(CONFIRM_COUNT);

    state_t                state;
    logic [RW-1:0]         run;
    logic [TIME_WIDTH-1:0] cand_time;
    logic [DATA_WIDTH-1:0] cand_peak;
    logic [DATA_WIDTH-1:0] upd_peak;

    // Evaluated sample stream: raw samples, or the registered 4-tap average.
    logic                  ev_vld;
    logic [DATA_WIDTH-1:0] ev_smp;
    logic [TIME_WIDTH-1:0] ev_time;

`ifdef ECHO_DET_MOVING_AVG_EN
    logic [2:0][DATA_WIDTH-1:0] taps;
    logic [2:0]                 tap_cnt;
    logic [DATA_WIDTH+1:0]      sum;
    logic [DATA_WIDTH+1:0]      avg;
    logic                       listening;

    assign listening = (state == BLANK) || (state == ARMED) ||
                       (state == CONFIRM) || (state == TRACK);
    assign sum = {2'b00, sample_in} + {2'b00, taps[0]} + {2'b00, taps[1]} + {2'b00, taps[2]};
    assign avg = sum >> 2;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            taps <= '0; tap_cnt <= '0; ev_vld <= 1'b0; ev_smp <= '0; ev_time <= '0;
        end else if (burst_start_in) begin
            taps <= '0; tap_cnt <= '0; ev_vld <= 1'b0; ev_smp <= '0; ev_time <= '0;
        end else begin
            ev_vld <= 1'b0;
            if (data_valid_in && listening) begin
                taps    <= {taps[1:0], sample_in};
                tap_cnt <= (tap_cnt < 3'd4) ? tap_cnt + 3'd1 : tap_cnt;
                ev_vld  <= (tap_cnt >= 3'd3);
                ev_smp  <= avg[DATA_WIDTH-1:0];
                ev_time <= time_in;
            end
        end
    end
`else
    assign ev_vld  = data_valid_in;
    assign ev_smp  = sample_in;
    assign ev_time = time_in;
`endif

    assign upd_peak = (ev_vld && ev_smp > cand_peak) ? ev_smp : cand_peak;
    assign busy_out = (state == BLANK) || (state == ARMED) ||
                      (state == CONFIRM) || (state == TRACK);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            run               <= '0;
            cand_time         <= '0;
            cand_peak         <= '0;
            echo_detected_out <= 1'b0;
            echo_valid_out    <= 1'b0;
            no_echo_out       <= 1'b0;
            echo_time_out     <= '0;
            peak_out          <= '0;
        end else begin
            echo_valid_out <= 1'b0;
            no_echo_out    <= 1'b0;
            if (burst_start_in) begin
                state             <= BLANK;
                run               <= '0;
                cand_time         <= '0;
                cand_peak         <= '0;
                echo_detected_out <= 1'b0;
                echo_time_out     <= '0;
                peak_out          <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    // The cycle that ends blanking already behaves as ARMED.
                    BLANK, ARMED: begin
                        if (state == ARMED || time_in >= BLANK_T) begin
                            if (time_in >= WIN_T) begin
                                state       <= DONE;
                                no_echo_out <= 1'b1;
                            end else if (ev_vld && ev_smp > TH) begin
                                cand_time <= ev_time;
                                cand_peak <= ev_smp;
                                run       <= RW'(1);
                                if (CONFIRM_COUNT == 1) begin
                                    state             <= TRACK;
                                    echo_detected_out <= 1'b1;
                                    echo_time_out     <= ev_time;
                                end else begin
                                    state <= CONFIRM;
                                end
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (time_in >= WIN_T) begin
                            state       <= DONE;
                            no_echo_out <= 1'b1;
                        end else if (ev_vld) begin
                            if (ev_smp > TH) begin
                                cand_peak <= upd_peak;
                                run       <= (run < CONF_MAX) ? run + RW'(1) : run;
                                if (run >= CONF_LAST) begin
                                    state             <= TRACK;
                                    echo_detected_out <= 1'b1;
                                    echo_time_out     <= cand_time;
                                end
                            end else begin
                                state     <= ARMED;
                                run       <= '0;
                                cand_time <= '0;
                                cand_peak <= '0;
                            end
                        end
                    end
                    // Window close and a low sample in the same cycle give one pulse.
                    TRACK: begin
                        cand_peak <= upd_peak;
                        if (time_in >= WIN_T || (ev_vld && ev_smp < LOW)) begin
                            state          <= DONE;
                            echo_valid_out <= 1'b1;
                            peak_out       <= upd_peak;
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
